// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 8-slot TDM demultiplexer.
// TDM_DEMUX_PARITY_EN extends each frame with a trailing even-parity slot.
package tdm_pkg;

    localparam int unsigned SLOTS       = 8;
    localparam int unsigned SEL_W       = $clog2(SLOTS);
    localparam int unsigned PARITY_SLOT = SLOTS;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned FRAME_SLOTS = SLOTS + 1;
    localparam int unsigned SLOT_W      = SEL_W + 1;
`else
    localparam int unsigned FRAME_SLOTS = SLOTS;
    localparam int unsigned SLOT_W      = SEL_W;
`endif

    localparam int unsigned LAST_SLOT   = FRAME_SLOTS - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame state flop and slot index counter: loads 1 on sync, advances on en,
// wraps after the last slot of a frame and drops to IDLE on missing sync.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    output logic [SLOT_W-1:0] slot,
    output logic              busy,
    output logic              last_slot
);

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (sync) begin
                        state_d = RUN;
                        slot_d  = SLOT_W'(1);
                    end
                end
                RUN: begin
                    // sync always restarts a frame; slot 0 without sync loses lock
                    if (sync) begin
                        slot_d = SLOT_W'(1);
                    end else if (slot_q == '0) begin
                        state_d = IDLE;
                        slot_d  = '0;
                    end else if (slot_q == SLOT_W'(LAST_SLOT)) begin
                        slot_d = '0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = '0;
                end
            endcase
        end
        last_d = (state_d == RUN) && (slot_d == SLOT_W'(LAST_SLOT));
    end

    assign slot      = slot_q;
    assign busy      = (state_q == RUN);
    assign last_slot = last_q;

endmodule

// File: rtl/tdm_demux8.sv
// 8:1 TDM receiver: collects slots into shadow registers and publishes all
// eight channels atomically per good frame. Option: TDM_DEMUX_PARITY_EN.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int unsigned DW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     y0,
    output logic [DW-1:0]     y1,
    output logic [DW-1:0]     y2,
    output logic [DW-1:0]     y3,
    output logic [DW-1:0]     y4,
    output logic [DW-1:0]     y5,
    output logic [DW-1:0]     y6,
    output logic [DW-1:0]     y7,
    output logic [SLOT_W-1:0] slot,
    output logic              frame_valid,
    output logic              sync_err,
    output logic              busy
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    logic [DW-1:0]    shadow [SLOTS];
    logic [DW-1:0]    y_q    [SLOTS];
    logic             last_slot;
    logic             is_data_c;
    logic [SEL_W-1:0] idx_c;

    tdm_slot_counter u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .slot      (slot),
        .busy      (busy),
        .last_slot (last_slot)
    );

    assign idx_c = SEL_W'(slot);

`ifdef TDM_DEMUX_PARITY_EN
    logic par_c;

    // Even parity across every bit of the eight buffered slots
    always_comb begin
        par_c = 1'b0;
        for (int k = 0; k < int'(SLOTS); k++) begin
            par_c = par_c ^ (^shadow[k]);
        end
    end

    assign is_data_c = (slot != SLOT_W'(PARITY_SLOT));
`else
    assign is_data_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SLOTS); k++) begin
                shadow[k] <= '0;
                y_q[k]    <= '0;
            end
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (en) begin
                if (sync) begin
                    // Partial frame is simply overwritten; it never reaches y_q
                    shadow[0] <= din;
                    if (busy && (slot != '0)) begin
                        sync_err <= 1'b1;
                    end
                end else if (busy) begin
                    if (slot == '0) begin
                        sync_err <= 1'b1;
                    end else begin
                        if (is_data_c) begin
                            shadow[idx_c] <= din;
                        end
`ifdef TDM_DEMUX_PARITY_EN
                        if (last_slot) begin
                            if (din[0] == par_c) begin
                                for (int k = 0; k < int'(SLOTS); k++) begin
                                    y_q[k] <= shadow[k];
                                end
                                frame_valid <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
                        end
`else
                        if (last_slot) begin
                            for (int k = 0; k < int'(SLOTS) - 1; k++) begin
                                y_q[k] <= shadow[k];
                            end
                            y_q[SLOTS-1] <= din;
                            frame_valid  <= 1'b1;
                        end
`endif
                    end
                end
            end
        end
    end

    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign y3 = y_q[3];
    assign y4 = y_q[4];
    assign y5 = y_q[5];
    assign y6 = y_q[6];
    assign y7 = y_q[7];

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed and random stimulus for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;
    import tdm_pkg::*;

    localparam int unsigned DW = 4;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif

    logic              clk, rst_n, en, sync;
    logic [DW-1:0]     din;
    logic [DW-1:0]     y0, y1, y2, y3, y4, y5, y6, y7;
    logic [SLOT_W-1:0] slot;
    logic              frame_valid, sync_err, busy;
`ifdef TDM_DEMUX_PARITY_EN
    logic              parity_err;
`endif

    tdm_demux8 #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .slot(slot), .frame_valid(frame_valid), .sync_err(sync_err), .busy(busy)
`ifdef TDM_DEMUX_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: collected slots of the frame in progress
    bit              m_run;
    logic [DW-1:0]   m_q[$];
    logic [8*DW-1:0] m_y;
    bit              m_fv, m_err, m_perr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y"},     64'({y7, y6, y5, y4, y3, y2, y1, y0}), 64'(m_y));
        chk({tag, ".slot"},  64'(slot), 64'(m_q.size()));
        chk({tag, ".fv"},    64'(frame_valid), 64'(m_fv));
        chk({tag, ".serr"},  64'(sync_err), 64'(m_err));
        chk({tag, ".busy"},  64'(busy), 64'(m_run));
`ifdef TDM_DEMUX_PARITY_EN
        chk({tag, ".perr"},  64'(parity_err), 64'(m_perr));
`endif
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_q.delete();
        m_y = '0;
        m_fv = 1'b0; m_err = 1'b0; m_perr = 1'b0;
    endtask

    task automatic model_update(input bit e, input bit s, input logic [DW-1:0] d);
        bit p;
        m_fv = 1'b0; m_err = 1'b0; m_perr = 1'b0;
        if (!e) return;
        if (!m_run) begin
            if (s) begin
                m_run = 1'b1;
                m_q = {d};
            end
        end else if (s) begin
            if (m_q.size() != 0) m_err = 1'b1;
            m_q = {d};
        end else if (m_q.size() == 0) begin
            m_err = 1'b1;
            m_run = 1'b0;
        end else begin
            m_q.push_back(d);
            if (m_q.size() == FR) begin
                p = 1'b0;
                for (int k = 0; k < 8; k++) p = p ^ (^m_q[k]);
                if (FR == 8 || m_q[FR-1][0] == p) begin
                    for (int k = 0; k < 8; k++) m_y[k*DW +: DW] = m_q[k];
                    m_fv = 1'b1;
                end else begin
                    m_perr = 1'b1;
                end
                m_q.delete();
            end
        end
    endtask

    task automatic step(input bit e, input bit s, input logic [DW-1:0] d, input string tag);
        en = e; sync = s; din = d;
        @(posedge clk);
        model_update(e, s, d);
        #1 check_all(tag);
    endtask

    task automatic send_frame(input logic [8*DW-1:0] v, input bit gate, input bit flip, input string tag);
        logic [DW-1:0] pd;
        bit p;
        p = flip;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k == 0, v[k*DW +: DW], tag);
            p = p ^ (^v[k*DW +: DW]);
            if (gate) step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), tag);
        end
        if (FR == 9) begin
            pd = DW'($urandom);
            pd[0] = p;
            step(1'b1, 1'b0, pd, tag);
        end
    endtask

    function automatic logic [8*DW-1:0] rand_frame();
        logic [8*DW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    initial begin
        int pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        logic [8*DW-1:0] v;
        bit s;

        rst_n = 1'b1; en = 1'b0; sync = 1'b0; din = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all("post_reset");

        // Basic frame, en every cycle
        for (int k = 0; k < 8; k++) v[k*DW +: DW] = DW'(pat[k]);
        send_frame(v, 1'b0, 1'b0, "basic");
        step(1'b0, 1'b0, '0, "basic_idle");

        // Back-to-back frames with en gated every other cycle
        send_frame(rand_frame(), 1'b1, 1'b0, "b2b_a");
        send_frame(rand_frame(), 1'b1, 1'b0, "b2b_b");

        // Early sync at slot 4
        v = rand_frame();
        for (int k = 0; k < 4; k++) step(1'b1, k == 0, v[k*DW +: DW], "early_part");
        send_frame(rand_frame(), 1'b0, 1'b0, "early_new");

        // Missing sync at slot 0 after a good frame, then an ignored slot
        send_frame(rand_frame(), 1'b0, 1'b0, "pre_miss");
        step(1'b1, 1'b0, DW'($urandom), "miss_sync");
        step(1'b1, 1'b0, DW'($urandom), "miss_ignored");
        step(1'b0, 1'b0, '0, "miss_quiet");

        // Asynchronous reset while at slot 5
        v = rand_frame();
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, v[k*DW +: DW], "rst_part");
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        @(posedge clk);
        #1 check_all("rst_hold");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, DW'($urandom), "rst_nosync");
        send_frame(rand_frame(), 1'b0, 1'b0, "rst_frame");

`ifdef TDM_DEMUX_PARITY_EN
        for (int k = 0; k < 8; k++) v[k*DW +: DW] = (k % 2 == 0) ? DW'(4'hA) : DW'(4'h5);
        send_frame(v, 1'b0, 1'b0, "par_ok");
        send_frame(rand_frame(), 1'b0, 1'b1, "par_bad");
        send_frame(rand_frame(), 1'b0, 1'b0, "par_next");
`endif

        // Random traffic, sync mostly aligned with frame starts
        for (int i = 0; i < 400; i++) begin
            if (m_q.size() == 0) s = ($urandom_range(0, 7) != 0);
            else                 s = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 3) != 0, s, DW'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receiving end of the 8:1 time-division select path. Takes a serial slot stream (one slot per enabled cycle, frame marked by `sync` on slot 0) and distributes slot k to output `y<k>`.
- Slot k corresponds to select value k, with s0 as the MSB of {s0,s1,s2}.
- Outputs are registered and update atomically once per complete frame. Sits after the serialising mux on the link, feeding parallel consumers.

Parameters:
- DW, 1, width of each slot / each output channel.
- SLOTS, 8, slots per frame; fixed at 8; the parameter exists for the package constant only.
- SEL_W, 3, slot index width, clog2(SLOTS).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  slot strobe; din/sync sampled only when en=1
- sync  input  1  frame marker, valid only with en; high means din is slot 0
- din  input  DW  serial slot data
- y0..y7  output  DW each  registered channel outputs; y<k> holds slot k of the last good frame
- slot  output  SEL_W  index of the next slot to be captured (0 when idle)
- frame_valid  output  1  one-cycle pulse: y0..y7 updated on this edge
- sync_err  output  1  one-cycle pulse: framing error detected
- busy  output  1  high while in state RUN

Behaviour:
- Reset (async, rst_n=0): state IDLE, slot=0, shadow regs=0, y0..y7=0, frame_valid=0, sync_err=0, busy=0.
- Cycles with en=0: no state change; frame_valid and sync_err return to 0.
- State IDLE:
  - en&sync: shadow[0]<=din, slot<=1, go RUN.
  - en&!sync: ignored, stay IDLE, no error.
- State RUN, en=1, slot=k:
  - For k in 1..7 with sync=0: shadow[k]<=din, slot<=k+1 (wraps 7->0).
  - Capture of slot 7: on the same edge, y0..y6<=shadow[0..6] and y7<=din. frame_valid=1 for the following cycle. slot<=0, stay RUN.
  - At slot 0: sync=1 starts the next frame exactly as from IDLE (back-to-back frames, no gap cycle). sync=0 means lost framing: sync_err pulse, go IDLE, slot=0.
  - sync=1 at slot k≠0 (early sync): sync_err pulse, partial frame discarded. The current din is taken as slot 0 of a new frame, slot<=1, stay RUN.
- y0..y7 never change except on a completed good frame; partial frames never leak to the outputs.
- Latency: slot-7 sample to outputs visible is 1 clock; frame_valid is high in that same cycle.
- Reset asserted mid-frame aborts immediately to reset values; no pulse is generated.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Frame is 9 slots; slot 8 carries even parity (XOR over all DW bits of slots 0..7, replicated into bit 0 of din, other bits ignored).
  - Output update and frame_valid move to the slot-8 capture edge and occur only if parity matches.
  - On mismatch: outputs are held, no frame_valid, a one-cycle parity_err pulse is generated, and the block stays RUN expecting sync at slot 0.
  - Adds output port parity_err (1 bit, reset 0). slot counter width becomes 4 and wraps 8->0.
- Undefined: 8-slot frame as above; no parity_err port.

Decomposition:
- Package tdm_pkg: SLOTS, SEL_W, state encoding (IDLE=1'b0, RUN=1'b1), parity-slot index constant.
- One natural sub-module: tdm_slot_counter. It holds the enable/wrap/load-1 counter plus the state flop, and outputs slot, busy and last_slot.
- Shadow registers, output registers and error pulses stay in the top module.

Test Plan:
- Reset then sync frame: en=1 every cycle, din=1,0,1,1,0,0,1,0 with sync on the first -> y0..y7=1,0,1,1,0,0,1,0 one cycle after slot 7; frame_valid high exactly 1 cycle; slot sequence 0,1..7,0.
- Two back-to-back frames, en gated every other cycle -> second frame's values replace the first only at its slot-7 edge; no gap needed; slot holds during en=0.
- Early sync at slot 4 -> sync_err 1 cycle, y unchanged; a new frame from that cycle completes 8 slots later with correct values.
- Missing sync at slot 0 after a good frame -> sync_err pulse, busy=0, slot=0, y holds last frame; a following en&!sync is ignored.
- rst_n low at slot 5 -> all outputs 0 asynchronously; after release, a full frame is still required before frame_valid.
- TDM_DEMUX_PARITY_EN: frame 0xA5 pattern with correct parity -> update and frame_valid; flipped parity bit -> parity_err pulse, outputs unchanged, next frame accepted.
